// File: rtl/cdb_arbiter.sv
// Common data bus transmitter: per-source result FIFOs feeding a round-robin
// arbiter that drives one registered {tag, data} broadcast per cycle.
module cdb_arbiter #(
  parameter int N_SRC      = 4,
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*TAG_W-1:0]  src_tag,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [SRC_W-1:0]        cdb_src
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(N_SRC - 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem    [N_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [N_SRC];
  logic [PTR_W-1:0] rd_ptr [N_SRC];
  logic [CNT_W-1:0] count  [N_SRC];

  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] winner;
  logic             any_cand;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  entry_t           head;

  // Ready depends only on the registered count, so a full FIFO being popped
  // this cycle still refuses the push; this keeps src_ready off the grant path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    src_ready = '0;
    cand      = '0;
    push      = '0;
    for (int i = 0; i < N_SRC; i++) begin
      src_ready[i] = (count[i] < DEPTH_C);
      cand[i]      = (count[i] != '0);
      push[i]      = src_valid[i] && src_ready[i] && !flush;
    end
  end

  // Round-robin scan starting at rr_ptr; first non-empty source wins.
  always_comb begin
    int idx;
    idx      = 0;
    any_cand = 1'b0;
    winner   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % N_SRC;
      if (!any_cand && cand[idx]) begin
        any_cand = 1'b1;
        winner   = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (any_cand && !flush) pop[winner] = 1'b1;
    head = mem[winner][rd_ptr[winner]];
  end

  // NOTE: FIFO storage has no reset; validity is tracked by count, so clearing
  // the payload would only add reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= {src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else if (flush) begin
      // rr_ptr survives recovery so fairness history is kept.
      for (int i = 0; i < N_SRC; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
      if (any_cand) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= head.tag;
        cdb_data  <= head.data;
        cdb_src   <= winner;
        rr_ptr    <= (winner == LAST_SRC) ? '0 : winner + 1'b1;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule
